// File: rtl/pe_operand_feeder_if.sv
// rtl/pe_operand_feeder_if.sv - PE operand feeder bus: control, buffer reads, PE operand stream
// Ports (master = feeder side):
//   in : start, hold, bias_in[7:0], fmap_rdata[7:0], wt_rdata[7:0]
//   out: fmap_addr[FADDR_W-1:0], wt_addr[WADDR_W-1:0], IMap[7:0], IWeight[7:0],
//        ImapVld, IweightVld, bias[7:0], win_last, omap_row[7:0], omap_col[7:0],
//        busy, done
interface pe_operand_feeder_if #(
  parameter int FADDR_W = 10,
  parameter int WADDR_W = 5
);
  logic               start;
  logic               hold;
  logic [7:0]         bias_in;
  logic [FADDR_W-1:0] fmap_addr;
  logic [7:0]         fmap_rdata;
  logic [WADDR_W-1:0] wt_addr;
  logic [7:0]         wt_rdata;
  logic [7:0]         IMap;
  logic [7:0]         IWeight;
  logic               ImapVld;
  logic               IweightVld;
  logic [7:0]         bias;
  logic               win_last;
  logic [7:0]         omap_row;
  logic [7:0]         omap_col;
  logic               busy;
  logic               done;

  modport master (
    input  start, hold, bias_in, fmap_rdata, wt_rdata,
    output fmap_addr, wt_addr, IMap, IWeight, ImapVld, IweightVld,
           bias, win_last, omap_row, omap_col, busy, done
  );

  modport slave (
    output start, hold, bias_in, fmap_rdata, wt_rdata,
    input  fmap_addr, wt_addr, IMap, IWeight, ImapVld, IweightVld,
           bias, win_last, omap_row, omap_col, busy, done
  );
endinterface

// File: rtl/pe_operand_feeder.sv
// rtl/pe_operand_feeder.sv - walks every KxK window of a feature map and streams operand pairs to the MAC PE
// Ports:
//   clk_cal : clock
//   rst_cal : asynchronous active-high reset
//   bus     : pe_operand_feeder_if.master (start/hold/bias_in control, feature and weight
//             buffer read ports, PE operand stream with window tags, busy/done status)
module pe_operand_feeder #(
  parameter int K       = 5,
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int FADDR_W = 10,
  parameter int WADDR_W = 5
) (
  input  logic                 clk_cal,
  input  logic                 rst_cal,
  pe_operand_feeder_if.master  bus
);

  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;

  localparam logic [7:0] K_LAST  = 8'(K - 1);
  localparam logic [7:0] OX_LAST = 8'(OUT_W - 1);
  localparam logic [7:0] OY_LAST = 8'(OUT_H - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] kx_q, kx_d;
  logic [7:0] ky_q, ky_d;
  logic [7:0] ox_q, ox_d;
  logic [7:0] oy_q, oy_d;
  logic [7:0] bias_q, bias_d;
  logic       vld_q;
  logic       win_last_q;
  logic [7:0] row_q;
  logic [7:0] col_q;

  logic run;
  logic issue;
  logic win_end;
  logic all_end;

  assign run     = (state_q == S_RUN);
  // Hold only freezes issue; the FSM stays in RUN so resumption is seamless.
  assign issue   = run && !bus.hold;
  assign win_end = (kx_q == K_LAST) && (ky_q == K_LAST);
  assign all_end = win_end && (ox_q == OX_LAST) && (oy_q == OY_LAST);

  always_comb begin
    state_d = state_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    bias_d  = bias_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          bias_d  = bus.bias_in;
          kx_d    = 8'd0;
          ky_d    = 8'd0;
          ox_d    = 8'd0;
          oy_d    = 8'd0;
        end
      end
      S_RUN: begin
        if (issue) begin
          // Nested odometer: kx fastest, then ky, ox, oy.
          if (kx_q == K_LAST) begin
            kx_d = 8'd0;
            if (ky_q == K_LAST) begin
              ky_d = 8'd0;
              if (ox_q == OX_LAST) begin
                ox_d = 8'd0;
                oy_d = oy_q + 8'd1;
              end else begin
                ox_d = ox_q + 8'd1;
              end
            end else begin
              ky_d = ky_q + 8'd1;
            end
          end else begin
            kx_d = kx_q + 8'd1;
          end
          // The final pair leaves RUN so the wrapped address is never issued.
          if (all_end) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) begin
      state_q    <= S_IDLE;
      kx_q       <= 8'd0;
      ky_q       <= 8'd0;
      ox_q       <= 8'd0;
      oy_q       <= 8'd0;
      bias_q     <= 8'd0;
      vld_q      <= 1'b0;
      win_last_q <= 1'b0;
      row_q      <= 8'd0;
      col_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      kx_q       <= kx_d;
      ky_q       <= ky_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      bias_q     <= bias_d;
      // Tags travel with valid so they line up with the returning read data.
      vld_q      <= issue;
      win_last_q <= issue && win_end;
      if (issue) begin
        row_q <= oy_q;
        col_q <= ox_q;
      end
    end
  end

  // Addresses are derived from the current counters, so during hold they sit
  // at the frozen (next-to-issue) position; outside RUN they are 0.
  assign bus.fmap_addr = run ? FADDR_W'((32'(oy_q) + 32'(ky_q)) * IMG_W + 32'(ox_q) + 32'(kx_q))
                             : '0;
  assign bus.wt_addr   = run ? WADDR_W'(32'(ky_q) * K + 32'(kx_q)) : '0;

  assign bus.ImapVld    = vld_q;
  assign bus.IweightVld = vld_q;
  assign bus.IMap       = vld_q ? bus.fmap_rdata : 8'd0;
  assign bus.IWeight    = vld_q ? bus.wt_rdata : 8'd0;
  assign bus.bias       = bias_q;
  assign bus.win_last   = win_last_q;
  assign bus.omap_row   = row_q;
  assign bus.omap_col   = col_q;
  assign bus.busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.done       = (state_q == S_DONE);

endmodule
